top_datapath: RTL and testbench
===============================

// Module: top_datapath
// PURPOSE
//  Pipelined mixing datapath. Captures four input words each cycle and computes arithmetic, bitwise,
//  CRC, rotate and statistics results. All results leave on one registered 474-bit status bus, y.
//  It is the top-level compute core; y feeds downstream observation and compare logic.
// PARAMETERS
//  none. All widths are fixed by the port list.
// PORTS
//  clk    input  1    rising-edge clock, the only clock
//  rst_n  input  1    synchronous, active-low reset, sampled on posedge clk
//  wire0  input  10   signed operand A
//  wire1  input  11   unsigned operand B; bits [5:0] also give the rotate amount
//  wire2  input  22   unsigned operand C
//  wire3  input  21   unsigned operand D
//  y      output 474  concatenation of registered result fields (MSB..LSB), listed below
// BEHAVIOUR
//  - Stage 1 (edge k): cap[63:0] <= {wire0, wire1, wire2, wire3}.
//    Field slices: w0=cap[63:54], w1=cap[53:43], w2=cap[42:21], w3=cap[20:0].
//  - Stage 2 (edge k+1): every field below is computed from cap.
//    acc and prod_d update at stage 3 (edge k+2).
//  - y field map, each field a register:
//    [473:410] cap_d2 = cap delayed 1 cycle
//    [409:346] cap
//    [345:313] prod   = $signed(w0) * $signed({1'b0,w2}), 33-bit signed
//    [312:280] prod_d = prod delayed 1 cycle
//    [279:256] sum    = w1 + w2 + w3, all zero-extended, 24 bits, never overflows
//    [255:233] diff   = {1'b0,w2} - {2'b0,w3}, 23-bit two's complement, wraps
//    [232:211] mix    = w2 ^ {w3, w0[0]}
//    [210:147] acc   <= acc + sign_extend64(prod); wraps mod 2^64, no saturation
//    [146:115] crc   <= CRC-32 (poly 04C11DB7) of crc, then 64 bits of cap MSB-first;
//                      no reflection, no final XOR
//    [114:51]  rot    = cap rotated left by w1[5:0] (0..63)
//    [50:44]   pop    = popcount(cap), 0..64
//    [43:36]   flags  = {w0<0, w2>w3, w1==0, ^cap, w2==w3, w1[10], acc[63] (pre-update), prod==0}
//    [35:20]   cnt    = free-running cycle counter; +1 every non-reset edge; FFFF wraps to 0000
//    [19:10]   max0  <= signed max(max0, w0)
//    [9:0]     min0  <= signed min(min0, w0)
//  - Reset (rst_n=0 at an edge): every field is 0, except crc = 32'hFFFFFFFF,
//    max0 = 10'h200 (-512) and min0 = 10'h1FF (+511).
//  - Reset has priority over all updates, including in mid-stream. After reset the pipeline
//    refills; the first stage-2 results reflect the first post-reset capture.
//  - No handshake: a new input is accepted every cycle. Throughput is 1 sample per cycle.
// CONFIGURATION
//  TOP_DATAPATH_CRC_EN
//   - Defined: the crc field behaves as specified above.
//   - Undefined: no CRC logic is built, and y[146:115] is a constant 32'h0, including during reset.
//   - All other fields are identical in both builds.
// TESTING
//  1 Reset: hold rst_n=0 for 2 edges -> y==0, except crc=FFFFFFFF, max0=200, min0=1FF.
//  2 Arithmetic: hold w0=3FF(-1), w1=0, w2=2, w3=0. Two edges after release ->
//    prod=1_FFFFFFFE, sum=2, diff=2, mix=3, flags[7], [6] and [5] set.
//  3 Accumulator: continue test 2 -> acc falls by 2 every cycle;
//    4 cycles after prod lands, acc=FFFFFFFF_FFFFFFF8 and flags[1]=1 on the next update.
//  4 Rotate: w0=0, w1=4, w2=0, w3=1 -> cap=00002000_00000001, rot=00020000_00000010, pop=2.
//  5 Stats: w0 sequence 5, -7, 3 -> max0=005, min0=3F9. Counter wraps after 65536 edges.
//  6 CRC build check: with TOP_DATAPATH_CRC_EN defined, crc changes every cycle and matches
//    a software CRC model. Without the macro, y[146:115] stays 0.

Source files
------------

// File: rtl/top_datapath.sv
// top_datapath: pipelined mixing datapath driving a 474-bit registered status bus; CRC field built only with TOP_DATAPATH_CRC_EN
module top_datapath (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [9:0]   wire0,
  input  logic [10:0]  wire1,
  input  logic [21:0]  wire2,
  input  logic [20:0]  wire3,
  output logic [473:0] y
);
  logic [63:0]        cap_q, cap_d, cap2_q;
  logic               v_q;
  logic [15:0]        cnt_q;
  logic signed [32:0] prod_q, prod_d, prodd_q;
  logic [23:0]        sum_q, sum_d;
  logic [22:0]        diff_q, diff_d;
  logic [21:0]        mix_q, mix_d;
  logic [63:0]        acc_q, acc_d;
  logic [63:0]        rot_q, rot_d;
  logic [127:0]       rot_dbl;
  logic [6:0]         pop_q, pop_d;
  logic [7:0]         flags_q, flags_d;
  logic [9:0]         max0_q, max0_d, min0_q, min0_d;
  logic [31:0]        crc;
  logic [9:0]         w0;
  logic [10:0]        w1;
  logic [21:0]        w2;
  logic [20:0]        w3;

  assign cap_d = {wire0, wire1, wire2, wire3};
  assign w0 = cap_q[63:54];
  assign w1 = cap_q[53:43];
  assign w2 = cap_q[42:21];
  assign w3 = cap_q[20:0];

  assign prod_d  = $signed(w0) * $signed({1'b0, w2});
  assign sum_d   = {13'b0, w1} + {2'b0, w2} + {3'b0, w3};
  assign diff_d  = {1'b0, w2} - {2'b0, w3};
  assign mix_d   = w2 ^ {w3, w0[0]};
  assign rot_dbl = {cap_q, cap_q} << w1[5:0];
  assign rot_d   = rot_dbl[127:64];
  assign flags_d = {w0[9], w2 > {1'b0, w3}, w1 == 11'd0, ^cap_q,
                    w2 == {1'b0, w3}, w1[10], acc_q[63], prod_d == 33'sd0};
  assign max0_d  = ($signed(w0) > $signed(max0_q)) ? w0 : max0_q;
  assign min0_d  = ($signed(w0) < $signed(min0_q)) ? w0 : min0_q;
  assign acc_d   = acc_q + {{31{prod_q[32]}}, prod_q};

  // population count of the captured word
  always_comb begin
    pop_d = '0;
    for (int i = 0; i < 64; i++) pop_d = pop_d + {6'b0, cap_q[i]};
  end

  // stage 1: capture inputs, track that cap holds a real post-reset sample, free-running counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_q <= '0;
      v_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      cap_q <= cap_d;
      v_q   <= 1'b1;
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // stage 2: results of the captured word; held while the pipeline refills after reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap2_q  <= '0;
      prod_q  <= '0;
      sum_q   <= '0;
      diff_q  <= '0;
      mix_q   <= '0;
      rot_q   <= '0;
      pop_q   <= '0;
      flags_q <= '0;
      max0_q  <= 10'h200;
      min0_q  <= 10'h1FF;
    end else if (v_q) begin
      cap2_q  <= cap_q;
      prod_q  <= prod_d;
      sum_q   <= sum_d;
      diff_q  <= diff_d;
      mix_q   <= mix_d;
      rot_q   <= rot_d;
      pop_q   <= pop_d;
      flags_q <= flags_d;
      max0_q  <= max0_d;
      min0_q  <= min0_d;
    end
  end

  // stage 3: delayed product and wrapping accumulator
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prodd_q <= '0;
      acc_q   <= '0;
    end else begin
      prodd_q <= prod_q;
      acc_q   <= acc_d;
    end
  end

`ifdef TOP_DATAPATH_CRC_EN
  logic [31:0] crc_q, crc_d;

  // CRC-32 over the 64 captured bits, MSB first, no reflection
  always_comb begin
    crc_d = crc_q;
    for (int i = 63; i >= 0; i--)
      crc_d = {crc_d[30:0], 1'b0} ^ ((crc_d[31] ^ cap_q[i]) ? 32'h04C11DB7 : 32'h0);
  end

  // stage 2 CRC register
  always_ff @(posedge clk) begin
    if (!rst_n) crc_q <= 32'hFFFFFFFF;
    else if (v_q) crc_q <= crc_d;
  end

  assign crc = crc_q;
`else
  assign crc = 32'h0;
`endif

  assign y = {cap2_q, cap_q, prod_q, prodd_q, sum_q, diff_q, mix_q, acc_q, crc,
              rot_q, pop_q, flags_q, cnt_q, max0_q, min0_q};
endmodule

// File: tb/tb_top_datapath.sv
// tb_top_datapath: scoreboard bench for top_datapath with directed vectors
module tb_top_datapath;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [9:0]   wire0;
  logic [10:0]  wire1;
  logic [21:0]  wire2;
  logic [20:0]  wire3;
  logic [473:0] y;

  localparam int F_CAP2 = 410, F_CAP = 346, F_PROD = 313, F_PRODD = 280, F_SUM = 256;
  localparam int F_DIFF = 233, F_MIX = 211, F_ACC = 147, F_CRC = 115, F_ROT = 51;
  localparam int F_POP = 44, F_FLG = 36, F_CNT = 20, F_MAX = 10, F_MIN = 0;

  typedef struct {
    int          cyc;
    int          lo;
    int          w;
    logic [63:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int ne = 0;
  int n_chk = 0;
  int n_pass = 0;

  top_datapath dut (
    .clk(clk), .rst_n(rst_n), .wire0(wire0), .wire1(wire1),
    .wire2(wire2), .wire3(wire3), .y(y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ne++;

  function automatic logic [31:0] crc64(input logic [31:0] c, input logic [63:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 63; i >= 0; i--) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
      else r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  task automatic exp_f(input int cyc, input string name, input int lo, input int w, input logic [63:0] e);
    chk_t c;
    c.cyc = cyc; c.lo = lo; c.w = w; c.exp = e; c.name = name;
    q.push_back(c);
  endtask

  task automatic exp_crc(input int cyc, input logic [31:0] e);
`ifdef TOP_DATAPATH_CRC_EN
    exp_f(cyc, "crc", F_CRC, 32, {32'h0, e});
`else
    exp_f(cyc, "crc_off", F_CRC, 32, 64'h0);
`endif
  endtask

  task automatic exp_reset(input int cyc);
    exp_f(cyc, "rst_cap2",  F_CAP2, 64, 64'h0);
    exp_f(cyc, "rst_cap",   F_CAP,  64, 64'h0);
    exp_f(cyc, "rst_prod",  F_PROD, 33, 64'h0);
    exp_f(cyc, "rst_prodd", F_PRODD, 33, 64'h0);
    exp_f(cyc, "rst_sum",   F_SUM,  24, 64'h0);
    exp_f(cyc, "rst_diff",  F_DIFF, 23, 64'h0);
    exp_f(cyc, "rst_mix",   F_MIX,  22, 64'h0);
    exp_f(cyc, "rst_acc",   F_ACC,  64, 64'h0);
    exp_crc(cyc, 32'hFFFFFFFF);
    exp_f(cyc, "rst_rot",   F_ROT,  64, 64'h0);
    exp_f(cyc, "rst_pop",   F_POP,  7,  64'h0);
    exp_f(cyc, "rst_flags", F_FLG,  8,  64'h0);
    exp_f(cyc, "rst_cnt",   F_CNT,  16, 64'h0);
    exp_f(cyc, "rst_max0",  F_MAX,  10, 64'h200);
    exp_f(cyc, "rst_min0",  F_MIN,  10, 64'h1FF);
  endtask

  task automatic go(input int n);
    while (ne < n) @(negedge clk);
  endtask

  task automatic drive(input logic [9:0] a, input logic [10:0] b, input logic [21:0] c, input logic [20:0] d);
    wire0 = a; wire1 = b; wire2 = c; wire3 = d;
  endtask

  // monitor: pop every expectation due at this cycle and compare against the bus
  always @(negedge clk) begin
    logic [473:0] m;
    logic [63:0]  got;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == ne) begin
        m   = (474'(1) << q[i].w) - 474'(1);
        got = 64'((y >> q[i].lo) & m);
        n_chk++;
        if (got === q[i].exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %h expected %h", q[i].name, ne, got, q[i].exp);
        q.delete(i);
      end else if (q[i].cyc < ne) begin
        n_chk++;
        $display("FAIL %s @cycle %0d: never sampled", q[i].name, q[i].cyc);
        q.delete(i);
      end
    end
  end

  initial begin
    logic [63:0] cap2;
    logic [31:0] c1;
    cap2 = 64'hFFC0_0000_0040_0000;
    c1   = crc64(32'hFFFFFFFF, cap2);
    drive(10'h1AA, 11'h555, 22'h2AAAAA, 21'h15555);
    exp_reset(2);
    exp_f(65537, "cnt_ffff", F_CNT, 16, 64'hFFFF);
    exp_f(65538, "cnt_wrap", F_CNT, 16, 64'h0);
    go(2);
    rst_n = 1'b1;
    drive(10'h3FF, 11'h0, 22'h2, 21'h0);
    exp_f(3, "t2_cap",   F_CAP,  64, cap2);
    exp_f(4, "t2_cap2",  F_CAP2, 64, cap2);
    exp_f(4, "t2_prod",  F_PROD, 33, 64'h1_FFFF_FFFE);
    exp_f(4, "t2_sum",   F_SUM,  24, 64'h2);
    exp_f(4, "t2_diff",  F_DIFF, 23, 64'h2);
    exp_f(4, "t2_mix",   F_MIX,  22, 64'h3);
    exp_f(4, "t2_flags", F_FLG,  8,  64'hF0);
    exp_f(4, "t2_cnt",   F_CNT,  16, 64'h2);
    exp_f(4, "t2_pop",   F_POP,  7,  64'h0B);
    exp_f(4, "t2_rot0",  F_ROT,  64, cap2);
    exp_f(4, "t2_max0",  F_MAX,  10, 64'h3FF);
    exp_f(4, "t2_min0",  F_MIN,  10, 64'h3FF);
    exp_f(4, "t2_acc",   F_ACC,  64, 64'h0);
    exp_crc(4, c1);
    exp_f(5, "t3_prodd", F_PRODD, 33, 64'h1_FFFF_FFFE);
    exp_f(5, "t3_acc1",  F_ACC,  64, 64'hFFFF_FFFF_FFFF_FFFE);
    exp_crc(5, crc64(c1, cap2));
    exp_f(8, "t3_acc4",  F_ACC,  64, 64'hFFFF_FFFF_FFFF_FFF8);
    exp_f(9, "t3_flags", F_FLG,  8,  64'hF2);
    go(8);
    drive(10'h0, 11'h4, 22'h0, 21'h1);
    exp_f(9,  "t4_cap",   F_CAP,  64, 64'h0000_2000_0000_0001);
    exp_f(10, "t4_rot",   F_ROT,  64, 64'h0002_0000_0000_0010);
    exp_f(10, "t4_pop",   F_POP,  7,  64'h2);
    exp_f(10, "t4_flags", F_FLG,  8,  64'h03);
    exp_f(10, "t4_diff",  F_DIFF, 23, 64'h7FFFFF);
    exp_f(10, "t4_sum",   F_SUM,  24, 64'h5);
    exp_f(10, "t4_mix",   F_MIX,  22, 64'h2);
    exp_f(10, "t4_prod",  F_PROD, 33, 64'h0);
    exp_f(10, "t4_acc",   F_ACC,  64, 64'hFFFF_FFFF_FFFF_FFF4);
    go(9);
    drive(10'h005, 11'h0, 22'h0, 21'h0);
    go(10);
    drive(10'h3F9, 11'h0, 22'h0, 21'h0);
    go(11);
    drive(10'h003, 11'h400, 22'h5, 21'h5);
    exp_f(12, "t5_acc",   F_ACC,  64, 64'hFFFF_FFFF_FFFF_FFF4);
    exp_f(13, "t5_max0",  F_MAX,  10, 64'h005);
    exp_f(13, "t5_min0",  F_MIN,  10, 64'h3F9);
    exp_f(13, "t5_flags", F_FLG,  8,  64'h1E);
    exp_f(13, "t5_sum",   F_SUM,  24, 64'h40A);
    exp_f(13, "t5_diff",  F_DIFF, 23, 64'h0);
    exp_f(13, "t5_prod",  F_PROD, 33, 64'hF);
    exp_f(13, "t5_mix",   F_MIX,  22, 64'hE);
    exp_f(14, "t5_acc",   F_ACC,  64, 64'h3);
    exp_f(14, "t5_prodd", F_PRODD, 33, 64'hF);
    go(65540);
    rst_n = 1'b0;
    drive(10'h1FF, 11'h7FF, 22'h3FFFFF, 21'h1FFFFF);
    exp_reset(65541);
    go(65541);
    rst_n = 1'b1;
    drive(10'h1FF, 11'h1, 22'h3, 21'h1);
    exp_f(65542, "rf_cap",  F_CAP,  64, 64'h7FC0_0800_0060_0001);
    exp_f(65542, "rf_cnt",  F_CNT,  16, 64'h1);
    exp_f(65543, "rf_sum",  F_SUM,  24, 64'h5);
    exp_f(65543, "rf_diff", F_DIFF, 23, 64'h2);
    exp_f(65543, "rf_max0", F_MAX,  10, 64'h1FF);
    exp_f(65543, "rf_min0", F_MIN,  10, 64'h1FF);
    exp_f(65543, "rf_prod", F_PROD, 33, 64'h5FD);
    exp_f(65543, "rf_acc",  F_ACC,  64, 64'h0);
    exp_f(65543, "rf_rot",  F_ROT,  64, 64'hFF80_1000_00C0_0002);
    exp_f(65543, "rf_pop",  F_POP,  7,  64'hD);
    exp_f(65543, "rf_cnt2", F_CNT,  16, 64'h2);
    exp_f(65544, "rf_acc1", F_ACC,  64, 64'h5FD);
    exp_f(65544, "rf_prodd", F_PRODD, 33, 64'h5FD);
    go(65546);
    foreach (q[i]) begin
      n_chk++;
      $display("FAIL %s @cycle %0d: never sampled", q[i].name, q[i].cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
